// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// uart_tx : 8-bit UART transmitter, valid/ready byte input, LSB first,
//           optional odd/even parity, 1 or 2 stop bits, one-entry hold buffer
// Revision : 1.0
// ============================================================================
module uart_tx #(
   parameter int F         = 8000000,
   parameter int BAUD      = 115200,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx,
   output logic       busy
);

   localparam int              c_MOD       = (F + BAUD / 2) / BAUD;
   localparam int              c_CW        = (c_MOD > 1) ? $clog2(c_MOD) : 1;
   localparam logic [c_CW-1:0] c_CNT_LAST  = c_CW'(c_MOD - 1);
   localparam logic            c_STOP_LAST = 1'(STOP_BITS - 1);

   if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
      $error("uart_tx: STOP_BITS must be 1 or 2");
   end
   if ((PARITY < 0) || (PARITY > 2)) begin : g_bad_parity
      $error("uart_tx: PARITY must be 0, 1 or 2");
   end

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [c_CW-1:0] cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic            stop_q, stop_d;
   logic            tx_q, tx_d;
   logic            hold_full_q, hold_full_d;
   logic [7:0]      hold_q, hold_d;
   logic [7:0]      shift_q, shift_d;

   logic            w_bit_end;
   logic            w_load;
   logic            w_par;
   logic [2:0]      w_idx_nxt;

   assign w_bit_end = (cnt_q == c_CNT_LAST);
   assign w_idx_nxt = idx_q + 3'd1;
   assign w_par     = (PARITY == 2) ? ^shift_q : ~^shift_q;

   assign tx_ready  = ~hold_full_q;
   assign tx        = tx_q;
   assign busy      = (state_q != S_IDLE);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      stop_d      = stop_q;
      tx_d        = tx_q;
      hold_full_d = hold_full_q;
      hold_d      = hold_q;
      shift_d     = shift_q;
      w_load      = 1'b0;

      if (state_q == S_IDLE || w_bit_end) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (hold_full_q) begin
               w_load  = 1'b1;
               state_d = S_START;
               tx_d    = 1'b0;
            end
         end
         S_START: begin
            if (w_bit_end) begin
               state_d = S_DATA;
               idx_d   = 3'd0;
               tx_d    = shift_q[0];
            end
         end
         S_DATA: begin
            if (w_bit_end) begin
               if (idx_q != 3'd7) begin
                  idx_d = w_idx_nxt;
                  tx_d  = shift_q[w_idx_nxt];
               end else if (PARITY != 0) begin
                  state_d = S_PARITY;
                  tx_d    = w_par;
               end else begin
                  state_d = S_STOP;
                  stop_d  = 1'b0;
                  tx_d    = 1'b1;
               end
            end
         end
         S_PARITY: begin
            if (w_bit_end) begin
               state_d = S_STOP;
               stop_d  = 1'b0;
               tx_d    = 1'b1;
            end
         end
         S_STOP: begin
            if (w_bit_end) begin
               if (stop_q == c_STOP_LAST) begin
                  // Chain straight into the next start bit when a byte waits.
                  if (hold_full_q) begin
                     w_load  = 1'b1;
                     state_d = S_START;
                     tx_d    = 1'b0;
                  end else begin
                     state_d = S_IDLE;
                     tx_d    = 1'b1;
                  end
               end else begin
                  stop_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
         end
      endcase

      if (w_load) begin
         shift_d     = hold_q;
         hold_full_d = 1'b0;
      end
      // A write in the same cycle as a load refills the hold register.
      if (tx_valid && !hold_full_q) begin
         hold_d      = tx_data;
         hold_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         idx_q       <= 3'd0;
         stop_q      <= 1'b0;
         tx_q        <= 1'b1;
         hold_full_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         stop_q      <= stop_d;
         tx_q        <= tx_d;
         hold_full_q <= hold_full_d;
      end
   end

   always_ff @(posedge clk) begin
      shift_q <= shift_d;
      hold_q  <= hold_d;
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// tb_uart_tx : directed self-checking bench for uart_tx across several builds
// Revision : 1.0
// ============================================================================
module tb_uart_tx;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] v;
   logic [4:0] rdy;
   logic [4:0] txl;
   logic [4:0] bsy;
   logic [7:0] d [5];

   int checks   = 0;
   int failures = 0;
   int bad;

   always #5 clk = ~clk;

   uart_tx #(.F(1000), .BAUD(100), .PARITY(0), .STOP_BITS(1)) u_base (
      .clk(clk), .reset(reset), .tx_data(d[0]), .tx_valid(v[0]),
      .tx_ready(rdy[0]), .tx(txl[0]), .busy(bsy[0]));
   uart_tx #(.F(1000), .BAUD(100), .PARITY(1), .STOP_BITS(1)) u_odd (
      .clk(clk), .reset(reset), .tx_data(d[1]), .tx_valid(v[1]),
      .tx_ready(rdy[1]), .tx(txl[1]), .busy(bsy[1]));
   uart_tx #(.F(1000), .BAUD(100), .PARITY(2), .STOP_BITS(1)) u_even (
      .clk(clk), .reset(reset), .tx_data(d[2]), .tx_valid(v[2]),
      .tx_ready(rdy[2]), .tx(txl[2]), .busy(bsy[2]));
   uart_tx #(.F(1000), .BAUD(100), .PARITY(0), .STOP_BITS(2)) u_stop2 (
      .clk(clk), .reset(reset), .tx_data(d[3]), .tx_valid(v[3]),
      .tx_ready(rdy[3]), .tx(txl[3]), .busy(bsy[3]));
   uart_tx #(.F(8000000), .BAUD(115200), .PARITY(0), .STOP_BITS(1)) u_rate (
      .clk(clk), .reset(reset), .tx_data(d[4]), .tx_valid(v[4]),
      .tx_ready(rdy[4]), .tx(txl[4]), .busy(bsy[4]));

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Samples one line bit per cycle starting now; bits[0] is the first bit on the line.
   task automatic frame(input int k, input int nbits, input logic [31:0] bits,
                        input int mod, input int drop_at, input string tag);
      int n;
      int nbad;
      n = 0;
      for (int b = 0; b < nbits; b++) begin
         nbad = 0;
         for (int c = 0; c < mod; c++) begin
            if (txl[k] !== bits[b] || bsy[k] !== 1'b1) nbad++;
            if (n == drop_at) v[k] = 1'b0;
            n++;
            @(negedge clk);
         end
         chk($sformatf("%s_bit%0d", tag, b), nbad, 0);
      end
   endtask

   task automatic idle_chk(input int k, input string tag);
      chk({tag, "_tx_idle"}, int'(txl[k]), 1);
      chk({tag, "_busy_low"}, int'(bsy[k]), 0);
      chk({tag, "_ready_high"}, int'(rdy[k]), 1);
   endtask

   initial begin
      reset = 1'b1;
      v     = '0;
      for (int k = 0; k < 5; k++) d[k] = 8'h00;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 5; k++) idle_chk(k, $sformatf("reset%0d", k));

      // Single byte 0x55, 8N1, MOD=10
      d[0] = 8'h55; v[0] = 1'b1;
      @(negedge clk);
      v[0] = 1'b0;
      chk("single_ready_low", int'(rdy[0]), 0);
      chk("single_tx_before_start", int'(txl[0]), 1);
      @(negedge clk);
      chk("single_ready_back", int'(rdy[0]), 1);
      frame(0, 10, 32'b1_01010101_0, 10, -1, "single");
      idle_chk(0, "single_end");
      repeat (3) @(negedge clk);

      // Back-to-back 0xA3 then 0x0F with valid held high
      d[0] = 8'hA3; v[0] = 1'b1;
      @(negedge clk);
      d[0] = 8'h0F;
      @(negedge clk);
      frame(0, 20, 32'b1_00001111_0_1_10100011_0, 10, 1, "b2b");
      idle_chk(0, "b2b_end");
      repeat (3) @(negedge clk);

      // Backpressure: hold full, tx_data wiggles while valid stays high
      d[0] = 8'h11; v[0] = 1'b1;
      @(negedge clk);
      d[0] = 8'h22;
      @(negedge clk);
      @(negedge clk);
      bad = 0;
      for (int i = 0; i < 80; i++) begin
         if (rdy[0] !== 1'b0) bad++;
         d[0] = 8'(8'hC0 + i);
         @(negedge clk);
      end
      v[0] = 1'b0;
      chk("bp_ready_held_low", bad, 0);
      repeat (19) @(negedge clk);
      frame(0, 10, 32'b1_00100010_0, 10, -1, "bp");
      idle_chk(0, "bp_end");
      repeat (3) @(negedge clk);

      // Parity on 0x07: even -> 1, odd -> 0
      d[2] = 8'h07; v[2] = 1'b1;
      @(negedge clk);
      v[2] = 1'b0;
      @(negedge clk);
      frame(2, 11, 32'b1_1_00000111_0, 10, -1, "even");
      idle_chk(2, "even_end");
      d[1] = 8'h07; v[1] = 1'b1;
      @(negedge clk);
      v[1] = 1'b0;
      @(negedge clk);
      frame(1, 11, 32'b1_0_00000111_0, 10, -1, "odd");
      idle_chk(1, "odd_end");

      // Two stop bits on 0xFF
      d[3] = 8'hFF; v[3] = 1'b1;
      @(negedge clk);
      v[3] = 1'b0;
      @(negedge clk);
      frame(3, 11, 32'b11_11111111_0, 10, -1, "stop2");
      idle_chk(3, "stop2_end");
      repeat (3) @(negedge clk);

      // Reset during cycle 45 of a 0x55 frame, then send 0x3C
      d[0] = 8'h55; v[0] = 1'b1;
      @(negedge clk);
      v[0] = 1'b0;
      repeat (45) @(negedge clk);
      chk("rst_mid_tx_data3", int'(txl[0]), 0);
      chk("rst_mid_busy", int'(bsy[0]), 1);
      reset = 1'b1;
      @(negedge clk);
      idle_chk(0, "rst_mid");
      reset = 1'b0;
      bad = 0;
      repeat (30) begin
         @(negedge clk);
         if (txl[0] !== 1'b1 || bsy[0] !== 1'b0) bad++;
      end
      chk("rst_quiet_line", bad, 0);
      d[0] = 8'h3C; v[0] = 1'b1;
      @(negedge clk);
      v[0] = 1'b0;
      @(negedge clk);
      frame(0, 10, 32'b1_00111100_0, 10, -1, "after_rst");
      idle_chk(0, "after_rst_end");

      // F=8 MHz, 115200 baud: MOD=69, 690-cycle frame
      d[4] = 8'h5A; v[4] = 1'b1;
      @(negedge clk);
      v[4] = 1'b0;
      @(negedge clk);
      frame(4, 10, 32'b1_01011010_0, 69, -1, "rate");
      idle_chk(4, "rate_end");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
